// File: rtl/count_arb_pkg.sv
// Shared types and constants for the count/LED sharing arbiter.
//   op_e        : per-requester opcode (clear, increment, decrement, load)
//   state_e     : arbiter FSM states
//   grant_ctx_t : opcode and load byte captured at grant time
package count_arb_pkg;

   localparam int unsigned LED_LSB = 16;
   localparam int unsigned LED_W   = 8;
   localparam int unsigned OP_W    = 2;

   typedef enum logic [OP_W-1:0] {
      OP_CLR = 2'b00,
      OP_INC = 2'b01,
      OP_DEC = 2'b10,
      OP_LD  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_BUSY    = 2'b01,
      ST_RELEASE = 2'b10
   } state_e;

   typedef struct packed {
      op_e              op;
      logic [LED_W-1:0] ld;
   } grant_ctx_t;

endpackage

// File: rtl/count_share_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req     : request vector
//   pointer : last granted index; search starts at pointer+1 and wraps
//   winner  : one-hot winner
//   idx     : winner index
//   valid   : any request present
module rr_pick #(
   parameter int unsigned NREQ  = 4,
   parameter int unsigned IDX_W = 2
) (
   input  logic [NREQ-1:0]  req,
   input  logic [IDX_W-1:0] pointer,
   output logic [NREQ-1:0]  winner,
   output logic [IDX_W-1:0] idx,
   output logic             valid
);

   logic [IDX_W-1:0] cand;

   // Walk from the farthest offset to the nearest so the nearest set request wins.
   always_comb begin
      winner = '0;
      idx    = '0;
      valid  = 1'b0;
      cand   = '0;
      for (int i = int'(NREQ); i >= 1; i--) begin
         cand = IDX_W'((32'(pointer) + 32'(i)) % NREQ);
         if (req[cand]) begin
            winner       = '0;
            winner[cand] = 1'b1;
            idx          = cand;
            valid        = 1'b1;
         end
      end
   end

endmodule

// File: rtl/count_share_arbiter.sv
// Shares one count register (and the LED byte taken from it) between NREQ
// requesters. A round-robin winner owns the counter for a bounded hold window.
//   CLK, RST : clock, asynchronous active-low reset
//   enable   : low freezes arbitration and counter updates
//   req/op/ld_data : per-requester request level, opcode, load byte
//   gnt/busy/done  : registered one-hot grant, busy flag, release pulse
//   count/led      : shared counter and count[23:16]
// Optional: define COUNT_ARB_SATURATE_EN to saturate increment/decrement.
module count_share_arbiter
   import count_arb_pkg::*;
#(
   parameter int unsigned NREQ     = 4,
   parameter int unsigned CNT_W    = 32,
   parameter int unsigned HOLD_CYC = 4
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    enable,
   input  logic [NREQ-1:0]         req,
   input  logic [OP_W*NREQ-1:0]    op,
   input  logic [LED_W*NREQ-1:0]   ld_data,
   output logic [NREQ-1:0]         gnt,
   output logic                    busy,
   output logic                    done,
   output logic [CNT_W-1:0]        count,
   output logic [LED_W-1:0]        led
);

   localparam int unsigned IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned HOLD_W = 8;

   state_e           state, state_n;
   logic [NREQ-1:0]  gnt_n;
   logic             busy_n, done_n;
   logic [CNT_W-1:0] count_n;
   logic [IDX_W-1:0] ptr, ptr_n, gidx, gidx_n;
   logic [HOLD_W-1:0] hold, hold_n;
   grant_ctx_t       ctx, ctx_n;
   logic             rel;

   logic [NREQ-1:0]  win_oh;
   logic [IDX_W-1:0] win_idx;
   logic             win_valid;

   logic [CNT_W-1:0] count_inc, count_dec, count_ld;

   rr_pick #(.NREQ(NREQ), .IDX_W(IDX_W)) u_pick (
      .req     (req),
      .pointer (ptr),
      .winner  (win_oh),
      .idx     (win_idx),
      .valid   (win_valid)
   );

`ifdef COUNT_ARB_SATURATE_EN
   assign count_inc = (&count)         ? count : count + CNT_W'(1);
   assign count_dec = (count == '0)    ? count : count - CNT_W'(1);
`else
   assign count_inc = count + CNT_W'(1);
   assign count_dec = count - CNT_W'(1);
`endif

   // Load byte lands on the LED field, everything else cleared.
   always_comb begin
      count_ld                    = '0;
      count_ld[LED_LSB +: LED_W]  = ctx.ld;
   end

   assign led = count[LED_LSB +: LED_W];

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state <= ST_IDLE;
         gnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         count <= '0;
         ptr   <= IDX_W'(NREQ - 1);
         gidx  <= '0;
         hold  <= '0;
         ctx   <= '0;
      end else begin
         state <= state_n;
         gnt   <= gnt_n;
         busy  <= busy_n;
         done  <= done_n;
         count <= count_n;
         ptr   <= ptr_n;
         gidx  <= gidx_n;
         hold  <= hold_n;
         ctx   <= ctx_n;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_n = state;
      gnt_n   = gnt;
      busy_n  = busy;
      done_n  = 1'b0;
      count_n = count;
      ptr_n   = ptr;
      gidx_n  = gidx;
      hold_n  = hold;
      ctx_n   = ctx;
      rel     = 1'b0;

      case (state)
         ST_IDLE: begin
            if (enable && win_valid) begin
               gnt_n     = win_oh;
               busy_n    = 1'b1;
               gidx_n    = win_idx;
               hold_n    = '0;
               ctx_n.op  = op_e'(op[win_idx*OP_W +: OP_W]);
               ctx_n.ld  = ld_data[win_idx*LED_W +: LED_W];
               state_n   = ST_BUSY;
            end
         end

         ST_BUSY: begin
            if (enable) begin
               case (ctx.op)
                  OP_CLR: begin
                     count_n = '0;
                     rel     = 1'b1;
                  end
                  OP_LD: begin
                     count_n = count_ld;
                     rel     = 1'b1;
                  end
                  OP_INC, OP_DEC: begin
                     // A dropped request releases without applying this cycle.
                     if (!req[gidx]) begin
                        rel = 1'b1;
                     end else begin
                        count_n = (ctx.op == OP_INC) ? count_inc : count_dec;
                        hold_n  = hold + HOLD_W'(1);
                        if (hold == HOLD_W'(HOLD_CYC - 1)) rel = 1'b1;
                     end
                  end
                  default: rel = 1'b1;
               endcase
               if (rel) begin
                  gnt_n   = '0;
                  busy_n  = 1'b0;
                  done_n  = 1'b1;
                  ptr_n   = gidx;
                  state_n = ST_RELEASE;
               end
            end
         end

         ST_RELEASE: state_n = ST_IDLE;

         default: begin
            gnt_n   = '0;
            busy_n  = 1'b0;
            state_n = ST_IDLE;
         end
      endcase
   end

endmodule
